// File: rtl/vga_timing_pkg.sv
// Shared VGA 800x600@60 timing constants and derived sync window bounds.
package vga_timing_pkg;

  localparam int unsigned CNT_W     = 11;
  localparam int unsigned CNT_LIMIT = 2047;

  localparam int unsigned DEF_H_VISIBLE = 800;
  localparam int unsigned DEF_H_FRONT   = 40;
  localparam int unsigned DEF_H_SYNC    = 128;
  localparam int unsigned DEF_H_BACK    = 88;
  localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int unsigned DEF_V_VISIBLE = 600;
  localparam int unsigned DEF_V_FRONT   = 1;
  localparam int unsigned DEF_V_SYNC    = 4;
  localparam int unsigned DEF_V_BACK    = 23;
  localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam bit DEF_H_POL = 1'b1;
  localparam bit DEF_V_POL = 1'b1;

  // Sync windows are half-open: [START, END)
  localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_timing_axis.sv
// One raster axis: wrapping counter with blanking and sync flags derived from the next count.
module vga_timing_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned FRONT   = DEF_H_FRONT,
  parameter int unsigned SYNC    = DEF_H_SYNC,
  parameter int unsigned BACK    = DEF_H_BACK,
  parameter bit          POL     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap_c,
  output logic             blnk,
  output logic             sync
);

  localparam int unsigned TOTAL = VISIBLE + FRONT + SYNC + BACK;

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] VIS_END  = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SYNC_LO  = CNT_W'(VISIBLE + FRONT);
  localparam logic [CNT_W-1:0] SYNC_HI  = CNT_W'(VISIBLE + FRONT + SYNC);

  if (TOTAL > CNT_LIMIT) begin : g_total_check
    $error("vga_timing_axis: TOTAL exceeds 11-bit counter range");
  end

  logic [CNT_W-1:0] next_count;

  assign wrap_c = step && (count == LAST);

  // Next count: advance on step, wrap from the last position
  always_comb begin
    next_count = count;
    if (step) begin
      next_count = (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // Count and its flags registered together so they stay coherent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~POL;
    end else begin
      count <= next_count;
      blnk  <= (next_count >= VIS_END);
      sync  <= ((next_count >= SYNC_LO) && (next_count < SYNC_HI)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: horizontal and vertical axes plus line/frame start pulses.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          H_POL     = DEF_H_POL,
  parameter bit          V_POL     = DEF_V_POL
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic             hsync,
  output logic             hblnk,
  output logic [CNT_W-1:0] vcount,
  output logic             vsync,
  output logic             vblnk,
  output logic             frame_start,
  output logic             line_start
);

  logic h_wrap_c;
  logic v_wrap_c;
  logic v_step_c;

  assign v_step_c = en && h_wrap_c;

  vga_timing_axis #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (H_POL)
  ) u_h_axis (
    .clk    (pclk),
    .rst    (rst),
    .step   (en),
    .count  (hcount),
    .wrap_c (h_wrap_c),
    .blnk   (hblnk),
    .sync   (hsync)
  );

  vga_timing_axis #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (V_POL)
  ) u_v_axis (
    .clk    (pclk),
    .rst    (rst),
    .step   (v_step_c),
    .count  (vcount),
    .wrap_c (v_wrap_c),
    .blnk   (vblnk),
    .sync   (vsync)
  );

  // Pulses mark the cycle in which the registered counts land on 0; they clear when idle
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap_c;
      frame_start <= v_wrap_c;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 800x600 raster plus a short-frame, low-polarity build.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b;
  logic hsync_a, hblnk_a, vsync_a, vblnk_a, fs_a, ls_a;
  logic hsync_b, hblnk_b, vsync_b, vblnk_b, fs_b, ls_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_timing dut_a (
    .pclk(clk), .rst(rst), .en(en),
    .hcount(hcount_a), .hsync(hsync_a), .hblnk(hblnk_a),
    .vcount(vcount_a), .vsync(vsync_a), .vblnk(vblnk_a),
    .frame_start(fs_a), .line_start(ls_a)
  );

  // Default horizontal timing, 11-line frame (vsync lines 7..8, vblnk lines 6..10), active-low syncs
  vga_timing #(
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_b (
    .pclk(clk), .rst(rst), .en(en),
    .hcount(hcount_b), .hsync(hsync_b), .hblnk(hblnk_b),
    .vcount(vcount_b), .vsync(vsync_b), .vblnk(vblnk_b),
    .frame_start(fs_b), .line_start(ls_b)
  );

  typedef struct {
    int t;
    int h;
    int v;
    bit hs;
    bit hb;
    bit vs;
    bit vb;
    bit ls;
    bit fs;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int cur;
    int fs_cnt_a, fs_cnt_b, fs_pos_b, ls_cnt_a, ls_cnt_b;
    int vs_act_b, vb_cnt_b, hs_low_b, hs_high_a, vs_high_a, vb_cnt_a;
    int vs_min_b, vs_max_b, vb_min_b;
    int prev_h, clocks, viol, ls_run, max_run;
    logic prev_hs, en_prev, wrapped;

    // t = en cycles since reset release; expected values for dut_a
    tbl[0]  = '{1,    1,    0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{799,  799,  0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{800,  800,  0, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{839,  839,  0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{840,  840,  0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{967,  967,  0, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{968,  968,  0, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{1055, 1055, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1056, 0,    1, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1057, 1,    1, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{2952, 840,  2, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{4068, 900,  3, 1, 1, 0, 0, 0, 0};

    // Reset held for 5 cycles with en=1
    rst = 1'b1;
    en  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_hcount", int'(hcount_a), 0);
    chk("rst_vcount", int'(vcount_a), 0);
    chk("rst_hsync",  int'(hsync_a), 0);
    chk("rst_vsync",  int'(vsync_a), 0);
    chk("rst_hblnk",  int'(hblnk_a), 0);
    chk("rst_vblnk",  int'(vblnk_a), 0);
    chk("rst_pulses", int'({fs_a, ls_a}), 0);
    chk("rst_b_syncs", int'({hsync_b, vsync_b}), 3);
    chk("rst_b_counts", int'(hcount_b) + int'(vcount_b), 0);
    rst = 1'b0;
    cur = 0;

    // Table-driven checkpoints along lines 0..3
    for (int i = 0; i < 12; i++) begin
      while (cur < tbl[i].t) begin
        @(negedge clk);
        cur++;
      end
      chk($sformatf("vec%0d_hcount", i), int'(hcount_a), tbl[i].h);
      chk($sformatf("vec%0d_vcount", i), int'(vcount_a), tbl[i].v);
      chk($sformatf("vec%0d_hsync", i),  int'(hsync_a),  int'(tbl[i].hs));
      chk($sformatf("vec%0d_hblnk", i),  int'(hblnk_a),  int'(tbl[i].hb));
      chk($sformatf("vec%0d_vsync", i),  int'(vsync_a),  int'(tbl[i].vs));
      chk($sformatf("vec%0d_vblnk", i),  int'(vblnk_a),  int'(tbl[i].vb));
      chk($sformatf("vec%0d_line_start", i),  int'(ls_a), int'(tbl[i].ls));
      chk($sformatf("vec%0d_frame_start", i), int'(fs_a), int'(tbl[i].fs));
    end

    // Async reset between edges at (900,3): outputs drop before the next edge
    chk("pre_rst_b_hsync", int'(hsync_b), 0);
    rst = 1'b1;
    #1;
    chk("async_hcount", int'(hcount_a), 0);
    chk("async_vcount", int'(vcount_a), 0);
    chk("async_hsync",  int'(hsync_a), 0);
    chk("async_hblnk",  int'(hblnk_a), 0);
    chk("async_b_hsync", int'(hsync_b), 1);
    chk("async_b_vcount", int'(vcount_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full short frame on dut_b (11 lines), dut_a runs the same 11 lines
    fs_cnt_a = 0; fs_cnt_b = 0; fs_pos_b = -1; ls_cnt_a = 0; ls_cnt_b = 0;
    vs_act_b = 0; vb_cnt_b = 0; hs_low_b = 0; hs_high_a = 0; vs_high_a = 0; vb_cnt_a = 0;
    vs_min_b = 9999; vs_max_b = -1; vb_min_b = 9999;
    for (int k = 1; k <= 11616; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("restart_hcount", int'(hcount_a), 1);
        chk("restart_vcount", int'(vcount_a), 0);
        chk("restart_pulses", int'({fs_a, ls_a}), 0);
      end
      if (fs_a) fs_cnt_a++;
      if (ls_a) ls_cnt_a++;
      if (ls_b) ls_cnt_b++;
      if (fs_b) begin
        fs_cnt_b++;
        fs_pos_b = k;
      end
      if (hsync_a) hs_high_a++;
      if (vsync_a) vs_high_a++;
      if (vblnk_a) vb_cnt_a++;
      if (!hsync_b) hs_low_b++;
      if (!vsync_b) begin
        vs_act_b++;
        if (int'(vcount_b) < vs_min_b) vs_min_b = int'(vcount_b);
        if (int'(vcount_b) > vs_max_b) vs_max_b = int'(vcount_b);
      end
      if (vblnk_b) begin
        vb_cnt_b++;
        if (int'(vcount_b) < vb_min_b) vb_min_b = int'(vcount_b);
      end
    end
    chk("frame_b_fs_count", fs_cnt_b, 1);
    chk("frame_b_fs_pos", fs_pos_b, 11616);
    chk("frame_b_end_hcount", int'(hcount_b), 0);
    chk("frame_b_end_vcount", int'(vcount_b), 0);
    chk("frame_b_ls_count", ls_cnt_b, 11);
    chk("frame_b_vsync_cycles", vs_act_b, 2112);
    chk("frame_b_vsync_first_line", vs_min_b, 7);
    chk("frame_b_vsync_last_line", vs_max_b, 8);
    chk("frame_b_vblnk_cycles", vb_cnt_b, 5280);
    chk("frame_b_vblnk_first_line", vb_min_b, 6);
    chk("frame_b_hsync_low_cycles", hs_low_b, 1408);
    chk("frame_a_hsync_high_cycles", hs_high_a, 1408);
    chk("frame_a_ls_count", ls_cnt_a, 11);
    chk("frame_a_fs_count", fs_cnt_a, 0);
    chk("frame_a_vsync_cycles", vs_high_a, 0);
    chk("frame_a_vblnk_cycles", vb_cnt_a, 0);
    chk("frame_a_end_vcount", int'(vcount_a), 11);

    // Enable gating: en toggles every cycle, starting low, for one full line
    prev_h  = int'(hcount_a);
    prev_hs = hsync_a;
    en      = 1'b0;
    en_prev = 1'b0;
    wrapped = 1'b0;
    clocks  = 0;
    viol    = 0;
    ls_run  = 0;
    max_run = 0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      clocks = c;
      if (!en_prev) begin
        if (int'(hcount_a) != prev_h || hsync_a != prev_hs || ls_a || fs_a) viol++;
      end else begin
        if (int'(hcount_a) != (prev_h + 1) % 1056) viol++;
      end
      ls_run = ls_a ? ls_run + 1 : 0;
      if (ls_run > max_run) max_run = ls_run;
      if (en_prev && hcount_a == 11'd0) begin
        wrapped = 1'b1;
        break;
      end
      prev_h  = int'(hcount_a);
      prev_hs = hsync_a;
      en      = ~en;
      en_prev = en;
    end
    chk("gate_wrapped", int'(wrapped), 1);
    chk("gate_clocks", clocks, 2112);
    chk("gate_hold_violations", viol, 0);
    chk("gate_pulse_len", max_run, 1);
    chk("gate_vcount", int'(vcount_a), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
